// File: rtl/sensor_pkg.sv
// Shared definitions for the cup-presence detector: state encoding, BCD thresholds
// and a BCD increment helper used by the ultrasonic interface.
package sensor_pkg;

  typedef enum logic [3:0] {
    StOcioso    = 4'd0,
    StPede      = 4'd1,
    StEspera    = 4'd2,
    StAvalia    = 4'd3,
    StIntervalo = 4'd4,
    StDecide    = 4'd5,
    StFim       = 4'd6,
    StFalha     = 4'd7
  } estado_t;

  localparam logic [11:0] LIMIAR_XICARA_ON  = 12'h150;
  localparam logic [11:0] LIMIAR_XICARA_OFF = 12'h180;
  localparam logic [11:0] BCD_MAX           = 12'hFFF;

  // Caller guarantees v != 12'h999; saturation is handled outside.
  function automatic logic [11:0] bcd_incrementa(input logic [11:0] v);
    logic [11:0] r;
    r = v;
    if (v[3:0] != 4'd9) begin
      r[3:0] = v[3:0] + 4'd1;
    end else begin
      r[3:0] = 4'd0;
      if (v[7:4] != 4'd9) begin
        r[7:4] = v[7:4] + 4'd1;
      end else begin
        r[7:4]  = 4'd0;
        r[11:8] = v[11:8] + 4'd1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/contador_m.sv
// Modulo-M cycle counter with synchronous clear; fim_o flags the terminal count M-1.
module contador_m #(
  parameter int unsigned M = 100,
  parameter int unsigned N = $clog2(M)
) (
  input  logic clock,
  input  logic zera_i,
  input  logic conta_i,
  output logic fim_o
);

  logic [N-1:0] q_q;

  always_ff @(posedge clock) begin
    if (zera_i) begin
      q_q <= '0;
    end else if (conta_i) begin
      if (q_q == N'(M - 1)) q_q <= '0;
      else                  q_q <= q_q + N'(1);
    end
  end

  assign fim_o = (q_q == N'(M - 1));

endmodule

// File: rtl/interface_hcsr04.sv
// HC-SR04 front end: fires a trigger pulse, times the echo and reports the distance
// as 3-digit BCD in tenths of a centimetre (12'hFFF when the echo exceeds 99.9 cm).
module interface_hcsr04
  import sensor_pkg::*;
#(
  parameter int unsigned TRIGGER_M     = 500,
  parameter int unsigned CICLOS_DECIMO = 294
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        medir_i,
  input  logic        echo_i,
  output logic        trigger_o,
  output logic [11:0] medida_o,
  output logic        pronto_o
);

  typedef enum logic [1:0] {IfOcioso, IfDisparo, IfAguarda, IfMede} if_estado_t;

  if_estado_t  estado_q;
  logic        echo_meta_q, echo_sinc_q;
  logic        trigger_q, pronto_q;
  logic [31:0] cnt_q;
  logic [15:0] sub_q;
  logic [11:0] bcd_q, medida_q;
  logic        sat_q;
  logic        conta, passo;

  assign conta = echo_sinc_q && (estado_q == IfAguarda || estado_q == IfMede);
  assign passo = conta && (sub_q == 16'(CICLOS_DECIMO - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q    <= IfOcioso;
      echo_meta_q <= 1'b0;
      echo_sinc_q <= 1'b0;
      trigger_q   <= 1'b0;
      pronto_q    <= 1'b0;
      cnt_q       <= '0;
      medida_q    <= '0;
    end else begin
      echo_meta_q <= echo_i;
      echo_sinc_q <= echo_meta_q;
      pronto_q    <= 1'b0;
      unique case (estado_q)
        IfOcioso: if (medir_i) begin
          estado_q  <= IfDisparo;
          trigger_q <= 1'b1;
          cnt_q     <= '0;
        end
        IfDisparo: begin
          if (cnt_q == 32'(TRIGGER_M - 1)) begin
            trigger_q <= 1'b0;
            estado_q  <= IfAguarda;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        IfAguarda: if (echo_sinc_q) estado_q <= IfMede;
        IfMede: if (!echo_sinc_q) begin
          medida_q <= sat_q ? BCD_MAX : bcd_q;
          pronto_q <= 1'b1;
          estado_q <= IfOcioso;
        end
        default: estado_q <= IfOcioso;
      endcase
    end
  end

  // Echo-width accumulator, counted directly in BCD tenths of a centimetre.
  always_ff @(posedge clock) begin
    if (reset || estado_q == IfOcioso) begin
      sub_q <= '0;
      bcd_q <= '0;
      sat_q <= 1'b0;
    end else if (conta) begin
      if (passo) begin
        sub_q <= '0;
        if (bcd_q == 12'h999) sat_q <= 1'b1;
        else                  bcd_q <= bcd_incrementa(bcd_q);
      end else begin
        sub_q <= sub_q + 16'd1;
      end
    end
  end

  assign trigger_o = trigger_q;
  assign medida_o  = medida_q;
  assign pronto_o  = pronto_q;

endmodule

// File: rtl/sensor_presenca_votos.sv
// Cup-presence detector: K-of-N vote over HC-SR04 samples with threshold hysteresis.
// Optional periodic self-start when SENSOR_PRESENCA_AUTO_EN is defined.
module sensor_presenca_votos
  import sensor_pkg::*;
#(
  parameter int unsigned N_AMOSTRAS    = 4,
  parameter int unsigned K_VOTOS       = 3,
  parameter logic [11:0] LIMIAR_ON     = LIMIAR_XICARA_ON,
  parameter logic [11:0] LIMIAR_OFF    = LIMIAR_XICARA_OFF,
  parameter int unsigned TIMEOUT_M     = 50000000,
  parameter int unsigned INTERVALO_M   = 3000000,
`ifdef SENSOR_PRESENCA_AUTO_EN
  parameter int unsigned PERIODO_M     = 100000000,
`endif
  parameter int unsigned TRIGGER_M     = 500,
  parameter int unsigned CICLOS_DECIMO = 294
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        medir_i,
`ifdef SENSOR_PRESENCA_AUTO_EN
  input  logic        auto_en_i,
`endif
  input  logic        echo_i,
  output logic        trigger_o,
  output logic        presente_o,
  output logic        pronto_o,
  output logic        timeout_o,
  output logic        ocupado_o,
  output logic [11:0] medida_min_o,
  output logic [3:0]  votos_o,
  output logic [3:0]  db_estado_o
);

  estado_t     estado_q;
  logic        presente_q, pronto_q, timeout_q, medir_sensor_q;
  logic [3:0]  indice_q, cont_votos_q, votos_q;
  logic [11:0] min_q, medida_min_q;

  logic        pronto_sensor, rst_sensor;
  logic [11:0] medida_sensor, limiar;
  logic        perto, fim_timeout, fim_intervalo, inicia;

  // A failed sample leaves the interface waiting for an echo; reset it with the failure.
  assign rst_sensor = reset | timeout_q;

  interface_hcsr04 #(
    .TRIGGER_M    (TRIGGER_M),
    .CICLOS_DECIMO(CICLOS_DECIMO)
  ) u_sensor (
    .clock    (clock),
    .reset    (rst_sensor),
    .medir_i  (medir_sensor_q),
    .echo_i   (echo_i),
    .trigger_o(trigger_o),
    .medida_o (medida_sensor),
    .pronto_o (pronto_sensor)
  );

  contador_m #(
    .M(TIMEOUT_M),
    .N($clog2(TIMEOUT_M))
  ) u_cont_timeout (
    .clock  (clock),
    .zera_i (reset | (estado_q == StPede)),
    .conta_i(estado_q == StEspera),
    .fim_o  (fim_timeout)
  );

  contador_m #(
    .M(INTERVALO_M),
    .N($clog2(INTERVALO_M))
  ) u_cont_intervalo (
    .clock  (clock),
    .zera_i (reset | (estado_q != StIntervalo)),
    .conta_i(estado_q == StIntervalo),
    .fim_o  (fim_intervalo)
  );

`ifdef SENSOR_PRESENCA_AUTO_EN
  logic [31:0] periodo_q;
  logic        dispara_auto;

  assign dispara_auto = auto_en_i && (estado_q == StOcioso) &&
                        (periodo_q == 32'(PERIODO_M - 1));

  always_ff @(posedge clock) begin
    if (reset || !auto_en_i || estado_q != StOcioso || medir_i || dispara_auto) begin
      periodo_q <= '0;
    end else begin
      periodo_q <= periodo_q + 32'd1;
    end
  end

  assign inicia = medir_i | dispara_auto;
`else
  assign inicia = medir_i;
`endif

  // presente_q is frozen for the whole decision, so the threshold is too.
  assign limiar = presente_q ? LIMIAR_OFF : LIMIAR_ON;
  assign perto  = (medida_sensor <= limiar);

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q       <= StOcioso;
      presente_q     <= 1'b0;
      pronto_q       <= 1'b0;
      timeout_q      <= 1'b0;
      medir_sensor_q <= 1'b0;
      indice_q       <= '0;
      cont_votos_q   <= '0;
      votos_q        <= '0;
      min_q          <= '0;
      medida_min_q   <= '0;
    end else begin
      pronto_q       <= 1'b0;
      timeout_q      <= 1'b0;
      medir_sensor_q <= 1'b0;
      unique case (estado_q)
        StOcioso: if (inicia) begin
          estado_q       <= StPede;
          indice_q       <= '0;
          cont_votos_q   <= '0;
          min_q          <= BCD_MAX;
          medir_sensor_q <= 1'b1;
        end
        StPede: estado_q <= StEspera;
        StEspera: begin
          if (pronto_sensor) begin
            estado_q <= StAvalia;
          end else if (fim_timeout) begin
            estado_q  <= StFalha;
            timeout_q <= 1'b1;
          end
        end
        StAvalia: begin
          cont_votos_q <= cont_votos_q + {3'b000, perto};
          if (medida_sensor < min_q) min_q <= medida_sensor;
          indice_q <= indice_q + 4'd1;
          if (indice_q == 4'(N_AMOSTRAS - 1)) estado_q <= StDecide;
          else                                estado_q <= StIntervalo;
        end
        StIntervalo: if (fim_intervalo) begin
          estado_q       <= StPede;
          medir_sensor_q <= 1'b1;
        end
        StDecide: begin
          presente_q   <= (cont_votos_q >= 4'(K_VOTOS));
          medida_min_q <= min_q;
          votos_q      <= cont_votos_q;
          pronto_q     <= 1'b1;
          estado_q     <= StFim;
        end
        StFim:   estado_q <= StOcioso;
        StFalha: estado_q <= StOcioso;
        default: estado_q <= StOcioso;
      endcase
    end
  end

  assign presente_o   = presente_q;
  assign pronto_o     = pronto_q;
  assign timeout_o    = timeout_q;
  assign ocupado_o    = (estado_q != StOcioso);
  assign medida_min_o = medida_min_q;
  assign votos_o      = votos_q;
  assign db_estado_o  = estado_q;

endmodule

// File: tb/tb_sensor_presenca_votos.sv
// Bench for sensor_presenca_votos: directed and random decisions checked against a
// vote-count reference model; echo widths are programmed in tenths of a centimetre.
module tb_sensor_presenca_votos;

  localparam int unsigned N       = 4;
  localparam int unsigned K       = 3;
  localparam int unsigned TMO     = 2000;
  localparam int unsigned INTV    = 50;
  localparam int          BUDGET  = 20000;
  localparam logic [11:0] LIM_ON  = 12'h150;
  localparam logic [11:0] LIM_OFF = 12'h180;

  logic        clock = 1'b0;
  logic        reset, medir, echo;
  logic        trigger, presente, pronto, timeout, ocupado;
  logic [11:0] medida_min;
  logic [3:0]  votos, db_estado;
`ifdef SENSOR_PRESENCA_AUTO_EN
  logic        auto_en = 1'b0;
`endif

  always #5 clock = ~clock;

  sensor_presenca_votos #(
    .N_AMOSTRAS   (N),
    .K_VOTOS      (K),
    .LIMIAR_ON    (LIM_ON),
    .LIMIAR_OFF   (LIM_OFF),
    .TIMEOUT_M    (TMO),
    .INTERVALO_M  (INTV),
    .TRIGGER_M    (4),
    .CICLOS_DECIMO(1)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .medir_i     (medir),
`ifdef SENSOR_PRESENCA_AUTO_EN
    .auto_en_i   (auto_en),
`endif
    .echo_i      (echo),
    .trigger_o   (trigger),
    .presente_o  (presente),
    .pronto_o    (pronto),
    .timeout_o   (timeout),
    .ocupado_o   (ocupado),
    .medida_min_o(medida_min),
    .votos_o     (votos),
    .db_estado_o (db_estado)
  );

  int checks = 0;
  int errors = 0;

  int amostras [4];
  bit mudo [4];
  int k_eco = 0;

  int n_pronto = 0, n_timeout = 0, run_espera = 0, ultima_espera = 0;

  bit          ref_presente = 1'b0;
  logic [11:0] ref_min      = 12'h000;
  logic [3:0]  ref_votos    = 4'd0;

  function automatic logic [11:0] to_bcd(input int d);
    if (d > 999) return 12'hFFF;
    return {4'(d / 100), 4'((d / 10) % 10), 4'(d % 10)};
  endfunction

  task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Echo model: after each trigger, hold echo high for the programmed number of cycles.
  initial begin
    echo = 1'b0;
    forever begin
      @(negedge trigger);
      repeat (3) @(negedge clock);
      if (k_eco < 4 && !mudo[k_eco]) begin
        echo = 1'b1;
        repeat (amostras[k_eco]) @(negedge clock);
        echo = 1'b0;
      end
      k_eco++;
    end
  end

  always @(negedge clock) begin
    if (pronto) n_pronto++;
    if (timeout) begin
      n_timeout++;
      ultima_espera = run_espera;
    end
    if (db_estado == 4'd2)      run_espera++;
    else if (db_estado != 4'd7) run_espera = 0;
  end

  task automatic pulsa_medir();
    @(negedge clock) medir = 1'b1;
    @(negedge clock) medir = 1'b0;
  endtask

  task automatic decisao(input string tag, input int d0, input int d1, input int d2,
                         input int d3, input int mute_idx);
    int p0, t0, c, nv;
    logic [11:0] mn, b, lim;
    amostras[0] = d0; amostras[1] = d1; amostras[2] = d2; amostras[3] = d3;
    for (int i = 0; i < 4; i++) mudo[i] = (i == mute_idx);
    k_eco = 0;
    p0 = n_pronto;
    t0 = n_timeout;
    pulsa_medir();
    c = 0;
    while (ocupado && c < BUDGET) begin
      @(negedge clock);
      c++;
    end
    verifica({tag, "_termina"}, 32'(ocupado), 32'd0);
    if (mute_idx >= 0) begin
      verifica({tag, "_timeout"}, 32'(n_timeout - t0), 32'd1);
      verifica({tag, "_pronto"}, 32'(n_pronto - p0), 32'd0);
      verifica({tag, "_espera"}, 32'(ultima_espera), 32'(TMO));
    end else begin
      lim = ref_presente ? LIM_OFF : LIM_ON;
      nv  = 0;
      mn  = 12'hFFF;
      for (int i = 0; i < 4; i++) begin
        b = to_bcd(amostras[i]);
        if (b <= lim) nv++;
        if (b < mn) mn = b;
      end
      ref_presente = (nv >= K);
      ref_votos    = 4'(nv);
      ref_min      = mn;
      verifica({tag, "_pronto"}, 32'(n_pronto - p0), 32'd1);
      verifica({tag, "_timeout"}, 32'(n_timeout - t0), 32'd0);
    end
    verifica({tag, "_presente"}, 32'(presente), 32'(ref_presente));
    verifica({tag, "_votos"}, 32'(votos), 32'(ref_votos));
    verifica({tag, "_min"}, 32'(medida_min), 32'(ref_min));
  endtask

  initial begin
    int p0, t0, c;
    reset = 1'b1;
    medir = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    verifica("rst_presente", 32'(presente), 32'd0);
    verifica("rst_pronto", 32'(pronto), 32'd0);
    verifica("rst_timeout", 32'(timeout), 32'd0);
    verifica("rst_min", 32'(medida_min), 32'd0);
    verifica("rst_votos", 32'(votos), 32'd0);
    verifica("rst_estado", 32'(db_estado), 32'd0);
    verifica("rst_ocupado", 32'(ocupado), 32'd0);

    decisao("perto", 100, 100, 100, 100, -1);
    decisao("histerese", 170, 170, 170, 300, -1);
    decisao("alcance_max", 1000, 1000, 1000, 1000, -1);
    decisao("poucos_votos", 160, 160, 100, 100, -1);
    decisao("falha", 120, 120, 120, 120, 1);

    // Abort: extra medir during INTERVALO is ignored, then reset mid-decision.
    amostras[0] = 100; amostras[1] = 100; amostras[2] = 100; amostras[3] = 100;
    for (int i = 0; i < 4; i++) mudo[i] = 1'b0;
    k_eco = 0;
    p0 = n_pronto;
    t0 = n_timeout;
    pulsa_medir();
    c = 0;
    while (db_estado != 4'd4 && c < BUDGET) begin
      @(negedge clock);
      c++;
    end
    verifica("abort_intervalo", 32'(db_estado), 32'd4);
    pulsa_medir();
    verifica("abort_medir_ignorado", 32'(db_estado), 32'd4);
    @(negedge clock) reset = 1'b1;
    @(negedge clock) reset = 1'b0;
    verifica("abort_presente", 32'(presente), 32'd0);
    verifica("abort_votos", 32'(votos), 32'd0);
    verifica("abort_min", 32'(medida_min), 32'd0);
    verifica("abort_estado", 32'(db_estado), 32'd0);
    verifica("abort_ocupado", 32'(ocupado), 32'd0);
    repeat (200) @(negedge clock);
    verifica("abort_sem_pronto", 32'(n_pronto - p0), 32'd0);
    verifica("abort_sem_timeout", 32'(n_timeout - t0), 32'd0);
    verifica("abort_ocioso", 32'(db_estado), 32'd0);
    ref_presente = 1'b0;
    ref_votos    = 4'd0;
    ref_min      = 12'h000;

    for (int r = 0; r < 6; r++) begin
      decisao($sformatf("rand%0d", r), int'($urandom_range(250, 80)),
              int'($urandom_range(250, 80)), int'($urandom_range(250, 80)),
              int'($urandom_range(250, 80)), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sensor_presenca_votos.md
Name: sensor_presenca_votos

Overview:
- Parametrised cup-presence detector for the coffee machine.
- On each request, takes N_AMOSTRAS HC-SR04 distance samples through the existing interface_hcsr04.
- Decides presence by K-of-N majority vote with threshold hysteresis and a per-sample timeout.
- Sits between the main control FSM and the ultrasonic sensor pins.

Parameters:
- N_AMOSTRAS, 4, samples per decision (1..15).
- K_VOTOS, 3, minimum "close" votes for presente=1 (1..N_AMOSTRAS).
- LIMIAR_ON, 12'h150, BCD distance (15.0 cm) at or below which a sample votes close while presente=0.
- LIMIAR_OFF, 12'h180, BCD distance (18.0 cm) at or below which a sample votes close while presente=1 (LIMIAR_OFF >= LIMIAR_ON).
- TIMEOUT_M, 50000000, clock cycles allowed per sample (1 s at 50 MHz).
- INTERVALO_M, 3000000, idle cycles between consecutive samples (60 ms).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- medir  in  1  start request, sampled in OCIOSO only
- echo  in  1  sensor echo pin
- trigger  out  1  sensor trigger pin (driven by interface_hcsr04)
- presente  out  1  registered presence decision, held between decisions
- pronto  out  1  one-cycle pulse when a decision completes
- timeout  out  1  one-cycle pulse when a sample times out
- ocupado  out  1  high in every state except OCIOSO
- medida_min  out  12  smallest BCD medida of the last completed decision
- votos  out  4  close-vote count of the last completed decision
- db_estado  out  4  current state encoding

Behaviour:
- Reset values: presente=0, pronto=0, timeout=0, medida_min=0, votos=0, state OCIOSO. Sample index, vote counter and both cycle counters are cleared.
- Reset also drives the interface_hcsr04 reset.
- Reset mid-operation aborts the decision. No pronto or timeout pulse is issued.
- Distances are 3-digit BCD. All comparisons are unsigned compares on the 12-bit value, which is ordinal for valid BCD. No arithmetic is performed on medida.
- States and transitions:
  - OCIOSO(0): medir=1 -> PEDE. Clear index, vote count and running minimum (min := 12'hFFF).
  - PEDE(1): drive a 1-cycle medir to interface_hcsr04, clear the timeout counter -> ESPERA.
  - ESPERA(2): on pronto_sensor -> AVALIA. Else, when the timeout counter reaches TIMEOUT_M-1 -> FALHA. If both occur in the same cycle, pronto_sensor wins.
  - AVALIA(3): close := (presente ? medida<=LIMIAR_OFF : medida<=LIMIAR_ON). Votes += close. min := min(min, medida). index++.
    - If index == N_AMOSTRAS-1 -> DECIDE.
    - Else -> INTERVALO.
  - INTERVALO(4): count INTERVALO_M cycles -> PEDE.
  - DECIDE(5): presente := (votes >= K_VOTOS). Latch medida_min and votos -> FIM.
  - FIM(6): pronto=1 for this cycle -> OCIOSO.
  - FALHA(7): timeout=1 for this cycle. presente, medida_min and votos are unchanged -> OCIOSO.
- The threshold is chosen from presente as it stood at the start of the decision. presente never changes during a decision.
- medir while ocupado=1 is ignored. No queueing.
- Latency with no timeouts and an echo returning in E cycles per sample is approximately N·(E + interface overhead) + (N-1)·INTERVALO_M + 3 cycles.
- A maximum-range medida (12'hFFF) is a valid far sample: it votes not-close.

Optional Feature:
- Macro: SENSOR_PRESENCA_AUTO_EN.
- Defined: adds parameter PERIODO_M (default 100000000) and input auto_en.
  - While auto_en=1 in OCIOSO, an internal counter starts a decision every PERIODO_M cycles, exactly as a medir pulse would.
  - An explicit medir restarts the counter.
  - The counter holds at 0 while auto_en=0 or ocupado=1.
- Undefined: no extra port or parameter. Decisions start only on medir.

Decomposition:
- Shared package sensor_pkg holds:
  - state encoding constants (OCIOSO..FALHA, 4-bit);
  - BCD threshold constants LIMIAR_XICARA_ON/OFF;
  - BCD_MAX=12'hFFF.
- Sub-modules: instantiate the existing interface_hcsr04. The two cycle counters (timeout and intervalo) are each a contador_m instance with N=$clog2(M).
- No new sub-module.

Test Plan (sim parameters: TIMEOUT_M=2000, INTERVALO_M=50, echo model returns a programmed BCD distance):
- Four samples at 12'h100, presente=0, medir pulse -> pronto pulses once; presente=1, votos=4, medida_min=12'h100.
- presente=1; samples 12'h170, 12'h170, 12'h170, 12'h300 -> hysteresis keeps presente=1, votos=3.
- presente=0; samples 12'h160, 12'h160, 12'h100, 12'h100 -> votos=2 < 3, presente stays 0, medida_min=12'h100.
- Echo never returns on sample 2 -> timeout pulses exactly once after 2000 cycles in ESPERA; no pronto; presente and medida_min unchanged; ocupado falls.
- medir re-pulsed while ocupado, and reset asserted in INTERVALO -> the extra medir has no effect; after reset, all outputs are 0, the state is OCIOSO, and no pronto or timeout pulse occurs.
- With SENSOR_PRESENCA_AUTO_EN, PERIODO_M=10000, auto_en=1 -> a decision starts every 10000 idle cycles; auto_en=0 -> no further starts.
